// File: rtl/kvs_resp_framer_if.sv
// Response-in / framed-out stream bundle for kvs_resp_framer.
// slave: the framer's side. master: the producer/consumer side.
interface kvs_resp_framer_if #(
    parameter int DATA_WIDTH = 512
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tlast;

    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/kvs_resp_framer.sv
// Sequence-stamps KVS responses, counts hit/err, frames a burst into one packet (optional trailer: KVS_RESP_TRAILER_EN).
// Latency: 1 cycle, through a single output register.
// Backpressure: the register reloads on the same cycle it drains; s_tready drops only while it is full and stalled.
module kvs_resp_framer #(
    parameter int DATA_WIDTH = 512,
    parameter int LEN_WIDTH  = 32,
    parameter int SEQ_LSB    = 416
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] burst_len,
    kvs_resp_framer_if.slave     io,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_WIDTH-1:0] hit_cnt,
    output logic [LEN_WIDTH-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, TRAIL} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, acc_q, hit_q, err_q;
    logic                  mvld_q, mlast_q, done_q;
    logic [DATA_WIDTH-1:0] mdat_q, stamped;
    logic                  in_fire, out_fire, all_in, last_out, arm;

    assign arm      = (state_q == IDLE) && start && (burst_len != '0);
    assign all_in   = (acc_q == len_q);
    assign in_fire  = io.s_tvalid && io.s_tready;
    assign out_fire = mvld_q && io.m_tready;
    // Once every response is in, the next drained beat must be the last response.
    assign last_out = out_fire && all_in && (state_q == RUN);

    always_comb begin
        stamped                 = io.s_tdata;
        stamped[SEQ_LSB +: 32]  = 32'(acc_q);
    end

`ifdef KVS_RESP_TRAILER_EN
    logic [DATA_WIDTH-1:0] trailer;
    always_comb begin
        trailer                     = '0;
        trailer[31:0]               = 32'(len_q);
        trailer[63:32]              = 32'(hit_q);
        trailer[95:64]              = 32'(err_q);
        trailer[DATA_WIDTH-1 -: 32] = 32'h4B565354;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (arm) state_d = RUN;
`ifdef KVS_RESP_TRAILER_EN
            RUN:   if (last_out) state_d = TRAIL;
            TRAIL: if (out_fire) state_d = IDLE;
`else
            RUN:   if (last_out) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io.s_tready = (state_q == RUN) && !all_in && (!mvld_q || io.m_tready);
        busy        = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            acc_q   <= '0;
            hit_q   <= '0;
            err_q   <= '0;
            mvld_q  <= 1'b0;
            mlast_q <= 1'b0;
            mdat_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            if (arm) begin
                len_q <= burst_len;
                acc_q <= '0;
                hit_q <= '0;
                err_q <= '0;
            end
            if (in_fire) begin
                acc_q  <= acc_q + 1'b1;
                hit_q  <= hit_q + LEN_WIDTH'(io.s_tdata[160] | io.s_tdata[161]);
                err_q  <= err_q + LEN_WIDTH'(io.s_tdata[162]);
                mvld_q <= 1'b1;
                mdat_q <= stamped;
`ifdef KVS_RESP_TRAILER_EN
                mlast_q <= 1'b0;
`else
                mlast_q <= (acc_q == len_q - 1'b1);
`endif
            end else if (out_fire) begin
`ifdef KVS_RESP_TRAILER_EN
                // Counters already include the last response, so the trailer loads as it drains.
                if (last_out) begin
                    mvld_q  <= 1'b1;
                    mdat_q  <= trailer;
                    mlast_q <= 1'b1;
                end else begin
                    mvld_q  <= 1'b0;
                end
`else
                mvld_q <= 1'b0;
`endif
            end
`ifdef KVS_RESP_TRAILER_EN
            done_q <= (state_q == TRAIL) && out_fire;
`else
            done_q <= last_out;
`endif
        end
    end

    assign io.m_tvalid = mvld_q;
    assign io.m_tdata  = mdat_q;
    assign io.m_tlast  = mlast_q;
    assign done        = done_q;
    assign hit_cnt     = hit_q;
    assign err_cnt     = err_q;
endmodule

// File: tb/tb_kvs_resp_framer.sv
// Randomized bench for kvs_resp_framer against a queue-based packet model.
module tb_kvs_resp_framer;
    localparam int DW = 512;
    localparam int LW = 32;
`ifdef KVS_RESP_TRAILER_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy, done;
    logic [LW-1:0] hit_cnt, err_cnt;

    kvs_resp_framer_if #(.DATA_WIDTH(DW)) bus ();

    kvs_resp_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .SEQ_LSB(416)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .io(bus.slave),
        .busy(busy), .done(done), .hit_cnt(hit_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src_q[$];
    logic [DW-1:0] words[$];
    logic [DW-1:0] out_dat[$];
    bit            out_last[$];
    int            out_cyc[$];
    int            done_cnt, done_cyc, stable_err, n_acc;
    bit            timed_out;
    int            exp_hit_last, exp_err_last;

    function automatic logic [DW-1:0] rand_word(input bit h1, input bit h2, input bit e);
        logic [DW-1:0] w;
        for (int k = 0; k < DW / 32; k++) w[k*32 +: 32] = $urandom;
        w[160] = h1;
        w[161] = h2;
        w[162] = e;
        return w;
    endfunction

    function automatic int model_hits(input logic [DW-1:0] ws[$]);
        int n = 0;
        foreach (ws[i]) if (ws[i][160] || ws[i][161]) n++;
        return n;
    endfunction

    function automatic int model_errs(input logic [DW-1:0] ws[$]);
        int n = 0;
        foreach (ws[i]) if (ws[i][162]) n++;
        return n;
    endfunction

    // Expected packet beat i: response i with its sequence number, or the statistics trailer.
    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] ws[$], input int i);
        logic [DW-1:0] w;
        if (i < ws.size()) begin
            w = ws[i];
            w[447:416] = i;
        end else begin
            w = '0;
            w[31:0]    = ws.size();
            w[63:32]   = model_hits(ws);
            w[95:64]   = model_errs(ws);
            w[511:480] = 32'h4B565354;
        end
        return w;
    endfunction

    function automatic bit model_last(input int len, input int i);
        return (i == len - 1 + TR);
    endfunction

    // Runs one burst from IDLE; vmode 0 = always valid, 1 = random; rmode 0 = ready, 1 = toggle, 2 = random.
    task automatic drive_burst(input int len, input int vmode, input int rmode,
                               input bit mid_start, input int abort_after);
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_dat = '0;
        int            post = -1;
        out_dat.delete(); out_last.delete(); out_cyc.delete();
        done_cnt = 0; done_cyc = -1; stable_err = 0; n_acc = 0; timed_out = 1'b0;
        start = 1'b1; burst_len = len;
        @(posedge clk); @(negedge clk);
        start = 1'b0; burst_len = '0;
        for (int c = 0; c < 400; c++) begin
            if (mid_start && c == 2) begin start = 1'b1; burst_len = 7; end
            else begin start = 1'b0; burst_len = '0; end
            bus.s_tvalid = (src_q.size() > 0) && (vmode == 0 || $urandom_range(0, 1) == 1);
            bus.s_tdata  = (src_q.size() > 0) ? src_q[0] : '0;
            bus.m_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            #1;
            if (prev_stall && (!bus.m_tvalid || bus.m_tdata !== prev_dat)) stable_err++;
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_dat   = bus.m_tdata;
            if (bus.s_tvalid && bus.s_tready) begin
                void'(src_q.pop_front());
                n_acc++;
            end
            if (bus.m_tvalid && bus.m_tready) begin
                out_dat.push_back(bus.m_tdata);
                out_last.push_back(bus.m_tlast);
                out_cyc.push_back(c);
            end
            @(posedge clk); @(negedge clk);
            if (done) begin done_cnt++; done_cyc = c; end
            if (abort_after > 0 && n_acc >= abort_after) break;
            if (done_cnt > 0) post++;
            if (post >= 2) break;
        end
        start = 1'b0; burst_len = '0;
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b0;
        if (done_cnt == 0 && abort_after == 0) timed_out = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; burst_len = '0;
        bus.s_tvalid = 1'b1; bus.s_tdata = rand_word(1, 1, 1); bus.m_tready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, busy, done, hit_cnt, err_cnt, bus.m_tdata} !== '0)
            begin errors++; $display("FAIL reset_outputs got sr=%b mv=%b ml=%b busy=%b done=%b hit=%0d err=%0d want all 0",
                bus.s_tready, bus.m_tvalid, bus.m_tlast, busy, done, hit_cnt, err_cnt); end
        rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({bus.s_tready, bus.m_tvalid, busy} !== 3'b000)
            begin errors++; $display("FAIL idle_no_accept got sr=%b mv=%b busy=%b want 000", bus.s_tready, bus.m_tvalid, busy); end
        bus.s_tvalid = 1'b0; bus.m_tready = 1'b0;
    endtask

    task automatic test_basic;
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(rand_word(i == 0 || i == 2, 0, i == 3));
        src_q = words;
        drive_burst(4, 0, 0, 0, 0);
        checks++;
        if (timed_out || out_dat.size() != 4 + TR)
            begin errors++; $display("FAIL basic_beats got %0d timeout=%0d want %0d", out_dat.size(), timed_out, 4 + TR); end
        for (int i = 0; i < out_dat.size() && i < 4 + TR; i++) begin
            checks++;
            if ({out_last[i], out_dat[i]} !== {model_last(4, i), model_beat(words, i)})
                begin errors++; $display("FAIL basic_beat%0d got last=%b %h want last=%b %h", i, out_last[i], out_dat[i],
                    model_last(4, i), model_beat(words, i)); end
        end
        checks++;
        if (out_cyc.size() > 0 && out_cyc[$] - out_cyc[0] != out_cyc.size() - 1)
            begin errors++; $display("FAIL basic_back_to_back got span %0d want %0d", out_cyc[$] - out_cyc[0], out_cyc.size() - 1); end
        checks++;
        if (hit_cnt !== 2 || err_cnt !== 1)
            begin errors++; $display("FAIL basic_counts got hit=%0d err=%0d want hit=2 err=1", hit_cnt, err_cnt); end
        checks++;
        if (done_cnt != 1 || out_cyc.size() == 0 || done_cyc != out_cyc[$] || busy !== 1'b0)
            begin errors++; $display("FAIL basic_done got pulses=%0d at %0d busy=%b want 1 pulse after last beat, busy 0",
                done_cnt, done_cyc, busy); end
        exp_hit_last = 2; exp_err_last = 1;
    endtask

    task automatic test_stall;
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back(rand_word($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)));
        src_q = words;
        drive_burst(3, 0, 1, 0, 0);
        checks++;
        if (stable_err != 0)
            begin errors++; $display("FAIL stall_stable got %0d changes while stalled want 0", stable_err); end
        checks++;
        if (timed_out || out_dat.size() != 3 + TR)
            begin errors++; $display("FAIL stall_beats got %0d timeout=%0d want %0d", out_dat.size(), timed_out, 3 + TR); end
        for (int i = 0; i < out_dat.size() && i < 3 + TR; i++) begin
            checks++;
            if ({out_last[i], out_dat[i]} !== {model_last(3, i), model_beat(words, i)})
                begin errors++; $display("FAIL stall_beat%0d got last=%b %h want last=%b %h", i, out_last[i], out_dat[i],
                    model_last(3, i), model_beat(words, i)); end
        end
        exp_hit_last = model_hits(words); exp_err_last = model_errs(words);
        checks++;
        if (hit_cnt !== LW'(exp_hit_last) || err_cnt !== LW'(exp_err_last))
            begin errors++; $display("FAIL stall_counts got hit=%0d err=%0d want hit=%0d err=%0d", hit_cnt, err_cnt,
                exp_hit_last, exp_err_last); end
    endtask

    task automatic test_ignore;
        start = 1'b1; burst_len = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.m_tvalid !== 1'b0 || hit_cnt !== LW'(exp_hit_last) || err_cnt !== LW'(exp_err_last))
            begin errors++; $display("FAIL zero_len_ignored got busy=%b mv=%b hit=%0d err=%0d want 0 0 %0d %0d",
                busy, bus.m_tvalid, hit_cnt, err_cnt, exp_hit_last, exp_err_last); end
        words.delete();
        for (int i = 0; i < 3; i++) words.push_back(rand_word(1, $urandom_range(0, 1), $urandom_range(0, 1)));
        src_q = words;
        drive_burst(3, 0, 1, 1, 0);
        checks++;
        if (timed_out || out_dat.size() != 3 + TR || done_cnt != 1)
            begin errors++; $display("FAIL mid_start_ignored got %0d beats %0d dones timeout=%0d want %0d beats 1 done",
                out_dat.size(), done_cnt, timed_out, 3 + TR); end
        for (int i = 0; i < out_dat.size() && i < 3 + TR; i++) begin
            checks++;
            if ({out_last[i], out_dat[i]} !== {model_last(3, i), model_beat(words, i)})
                begin errors++; $display("FAIL mid_start_beat%0d got last=%b %h want last=%b %h", i, out_last[i], out_dat[i],
                    model_last(3, i), model_beat(words, i)); end
        end
        checks++;
        if (hit_cnt !== LW'(model_hits(words)) || err_cnt !== LW'(model_errs(words)))
            begin errors++; $display("FAIL mid_start_counts got hit=%0d err=%0d want hit=%0d err=%0d", hit_cnt, err_cnt,
                model_hits(words), model_errs(words)); end
    endtask

    task automatic test_random;
        int len;
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, 9);
            words.delete();
            for (int i = 0; i < len; i++)
                words.push_back(rand_word($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1)));
            src_q = words;
            drive_burst(len, 1, 2, 0, 0);
            checks++;
            if (timed_out || out_dat.size() != len + TR || done_cnt != 1 || stable_err != 0)
                begin errors++; $display("FAIL rand%0d_beats got %0d beats %0d dones %0d unstable timeout=%0d want %0d 1 0",
                    b, out_dat.size(), done_cnt, stable_err, timed_out, len + TR); end
            for (int i = 0; i < out_dat.size() && i < len + TR; i++) begin
                checks++;
                if ({out_last[i], out_dat[i]} !== {model_last(len, i), model_beat(words, i)})
                    begin errors++; $display("FAIL rand%0d_beat%0d got last=%b %h want last=%b %h", b, i, out_last[i],
                        out_dat[i], model_last(len, i), model_beat(words, i)); end
            end
            checks++;
            if (hit_cnt !== LW'(model_hits(words)) || err_cnt !== LW'(model_errs(words)))
                begin errors++; $display("FAIL rand%0d_counts got hit=%0d err=%0d want hit=%0d err=%0d", b, hit_cnt, err_cnt,
                    model_hits(words), model_errs(words)); end
        end
    endtask

    task automatic test_reset_mid;
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(rand_word(1, 0, 1));
        src_q = words;
        drive_burst(5, 0, 0, 0, 2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_tready, bus.m_tvalid, bus.m_tlast, busy, done, hit_cnt, err_cnt, bus.m_tdata} !== '0)
            begin errors++; $display("FAIL reset_mid_outputs got sr=%b mv=%b ml=%b busy=%b done=%b hit=%0d err=%0d want all 0",
                bus.s_tready, bus.m_tvalid, bus.m_tlast, busy, done, hit_cnt, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        words.delete();
        words.push_back(rand_word(0, 1, 1));
        src_q = words;
        drive_burst(1, 0, 0, 0, 0);
        checks++;
        if (timed_out || out_dat.size() != 1 + TR || done_cnt != 1)
            begin errors++; $display("FAIL after_reset_beats got %0d beats %0d dones want %0d 1", out_dat.size(), done_cnt, 1 + TR); end
        for (int i = 0; i < out_dat.size() && i < 1 + TR; i++) begin
            checks++;
            if ({out_last[i], out_dat[i]} !== {model_last(1, i), model_beat(words, i)})
                begin errors++; $display("FAIL after_reset_beat%0d got last=%b %h want last=%b %h", i, out_last[i], out_dat[i],
                    model_last(1, i), model_beat(words, i)); end
        end
        checks++;
        if (hit_cnt !== 1 || err_cnt !== 1)
            begin errors++; $display("FAIL after_reset_counts got hit=%0d err=%0d want 1 1", hit_cnt, err_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
